// File: rtl/led_sbox_layer_serial.sv
// Serialised masked S-box layer for LED: streams each nibble of every share
// through an external fixed-latency masked S-box core and reassembles shares.
module led_sbox_layer_serial #(
   parameter int NIBBLES  = 16,
   parameter int SHARES   = 3,
   parameter int CORE_LAT = 3,
   parameter int RND_W    = 26
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SHARES*4*NIBBLES-1:0]   in_state,
   input  logic                          rnd_valid,
   output logic                          rnd_ready,
   input  logic [RND_W-1:0]              rnd_in,
   output logic [SHARES*4-1:0]           core_din,
   output logic [RND_W-1:0]              core_rnd,
   input  logic [SHARES*4-1:0]           core_dout,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SHARES*4*NIBBLES-1:0]   out_state
);

   localparam int SW = 4 * NIBBLES;
   localparam int CW = $clog2(NIBBLES + 1);
   localparam logic [CW-1:0] C_LAST = CW'(NIBBLES);
   localparam logic [CW-1:0] C_PEN  = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [SW-1:0]       r_share [SHARES];
   logic [SW-1:0]       r_out   [SHARES];
   logic [CW-1:0]       r_issue_cnt;
   logic [CW-1:0]       r_cap_cnt;
   logic [CORE_LAT-1:0] r_vpipe;
   logic                w_issue;
   logic                w_cap;
   logic                w_last_cap;
   logic                w_accept;
   logic                w_release;

   // a nibble goes to the core only when fresh randomness is present
   assign w_issue    = (r_state == S_FEED) & rnd_valid & (r_issue_cnt < C_LAST);
   assign w_cap      = r_vpipe[CORE_LAT-1];
   assign w_last_cap = w_cap & (r_cap_cnt == C_PEN);
   assign w_accept   = (r_state == S_IDLE) & in_valid;
   assign w_release  = (r_state == S_DONE) & out_ready;

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state logic; last capture may land while still in FEED for short latencies
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (in_valid) w_next = S_FEED;
         S_FEED: begin
            if (w_last_cap)                 w_next = S_DONE;
            else if (r_issue_cnt == C_LAST) w_next = S_DRAIN;
         end
         S_DRAIN: if (w_last_cap || r_cap_cnt == C_LAST) w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // outputs; core inputs are forced to zero outside issue cycles so no share residue leaks
   always_comb begin
      in_ready  = (r_state == S_IDLE);
      out_valid = (r_state == S_DONE);
      rnd_ready = w_issue;
      core_rnd  = w_issue ? rnd_in : '0;
      core_din  = '0;
      out_state = '0;
      for (int s = 0; s < SHARES; s++) begin
         if (w_issue) core_din[4*s +: 4] = r_share[s][{r_issue_cnt, 2'b00} +: 4];
         out_state[s*SW +: SW] = r_out[s];
      end
   end

   // datapath: share capture, issue/capture counters, in-flight valid pipe
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SHARES; s++) begin
            r_share[s] <= '0;
            r_out[s]   <= '0;
         end
         r_issue_cnt <= '0;
         r_cap_cnt   <= '0;
         r_vpipe     <= '0;
      end else begin
         r_vpipe <= (r_vpipe << 1) | CORE_LAT'(w_issue);
         if (w_accept) begin
            for (int s = 0; s < SHARES; s++) r_share[s] <= in_state[s*SW +: SW];
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
         end
         if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
         if (w_cap) begin
            for (int s = 0; s < SHARES; s++)
               r_out[s][{r_cap_cnt, 2'b00} +: 4] <= core_dout[4*s +: 4];
            r_cap_cnt <= r_cap_cnt + 1'b1;
         end
         if (w_release) begin
            for (int s = 0; s < SHARES; s++) begin
               r_share[s] <= '0;
               r_out[s]   <= '0;
            end
         end
      end
   end

endmodule
